// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store-size encodings, request FSM
// states and the queued entry layout.
package store_buffer_pkg;

  // funct3 encodings of the store-size selector
  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  // Memory request FSM
  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } req_state_t;

  // One queued store: word address, lane-replicated data, byte enables
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_align.sv
// store_align: combinational byte-lane placement for SB/SH/SW stores.
// Produces replicated write data, the byte-enable mask, a legal-selector
// flag and a misalignment flag (SH on an odd byte, SW off a word boundary).
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [2:0]  st_sel,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic        legal,
  output logic        misalign
);

  // Lane replication and mask generation from the low address bits
  always_comb begin
    wdata    = '0;
    wmask    = '0;
    legal    = 1'b0;
    misalign = 1'b0;
    case (st_sel)
      ST_SB: begin
        legal = 1'b1;
        wdata = {4{data[7:0]}};
        wmask = 4'b0001 << addr;
      end
      ST_SH: begin
        legal    = 1'b1;
        misalign = addr[0];
        if (addr == 2'b01) begin
          // halfword straddling the middle lanes
          wdata = {8'h00, data[15:0], 8'h00};
          wmask = 4'b0110;
        end else if (addr[1]) begin
          wdata = {2{data[15:0]}};
          wmask = 4'b1100;
        end else begin
          wdata = {2{data[15:0]}};
          wmask = 4'b0011;
        end
      end
      ST_SW: begin
        legal    = 1'b1;
        misalign = |addr;
        wdata    = data;
        wmask    = 4'b1111;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: queues aligned stores in a DEPTH-entry FIFO and drains them
// to data memory over a req/ack handshake.
// Optional feature macro: STORE_MISALIGN_TRAP_EN -- misaligned SH/SW stores
// are consumed but not queued, and st_misalign pulses for one cycle.
//
// state  | meaning
// S_IDLE | no request presented to memory
// S_REQ  | head entry presented on mem_*; popped on mem_ack
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               StSel,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wmask,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic                     st_misalign
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t          fifo_mem [DEPTH];
  sb_entry_t          head_entry;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;
  req_state_t         state;
  req_state_t         state_nxt;

  logic [31:0]        al_wdata;
  logic [3:0]         al_wmask;
  logic               al_legal;
  logic               al_misalign;
  logic               enq_ok;
  logic               full;
  logic               push;
  logic               pop;

  store_align u_align (
    .addr     (st_addr[1:0]),
    .data     (st_data),
    .st_sel   (StSel),
    .wdata    (al_wdata),
    .wmask    (al_wmask),
    .legal    (al_legal),
    .misalign (al_misalign)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  assign enq_ok = al_legal && !al_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = al_misalign;
  assign enq_ok          = al_legal;
`endif

  // st_ready depends only on registered occupancy, never on mem_ack
  assign full     = (count == CW'(DEPTH));
  assign st_ready = !full;
  assign mem_req  = (state == S_REQ);
  assign push     = st_valid && st_ready && enq_ok;
  assign pop      = mem_req && mem_ack;

  // Entry storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= '{addr: st_addr[31:2], wdata: al_wdata, wmask: al_wmask};
    end
  end

  // Head/tail pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  // Occupancy tracking; push and pop together leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Request FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Request FSM next state; IDLE looks at registered count so a push into
  // an empty buffer raises mem_req one cycle later
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (count != '0) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (pop && !push && (count == CW'(1))) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory-side outputs are zero whenever no request is presented
  always_comb begin
    head_entry = fifo_mem[head];
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    if (mem_req) begin
      mem_addr  = {head_entry.addr, 2'b00};
      mem_wdata = head_entry.wdata;
      mem_wmask = head_entry.wmask;
    end
  end

  assign sb_empty = (count == '0);
  assign sb_count = count;

`ifdef STORE_MISALIGN_TRAP_EN
  // One-cycle flag after accepting a misaligned SH/SW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_misalign <= 1'b0;
    else        st_misalign <= st_valid && st_ready && al_legal && al_misalign;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus pushes expected memory writes
// into a queue, a negedge monitor pops and compares on every accepted request.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  StSel;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        sb_empty;
  logic [2:0]  sb_count;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        st_misalign;
`endif

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .StSel     (StSel),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .sb_empty  (sb_empty),
    .sb_count  (sb_count)
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    .st_misalign (st_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wd;
    logic [3:0]  m;
    bit          legal;
    bit          mis;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    exp_t e;
    e.addr  = a;
    e.wdata = wd;
    e.mask  = m;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; drives a store for one accepting edge
  task automatic push_store(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    StSel    = sel;
    st_addr  = a;
    st_data  = d;
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (sb_empty && !mem_req) break;
      @(posedge clk); #1;
    end
    check("drain_empty_noreq", {30'd0, sb_empty, mem_req}, 32'd2);
  endtask

  // Monitor: a request with ack at the negedge pops at the next posedge
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_addr=%h expected=none", mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_addr",  mem_addr,  e.addr);
        check("pop_wdata", mem_wdata, e.wdata);
        check("pop_wmask", {28'd0, mem_wmask}, {28'd0, e.mask});
      end
    end
  end

  initial begin
    bit enq;
    vecs[0] = '{3'b000, 32'h0000_1003, 32'h0000_00EF, 32'hEFEF_EFEF, 4'b1000, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 32'h0000_2001, 32'h0000_BEEF, 32'h00BE_EF00, 4'b0110, 1'b1, 1'b1};
    vecs[2] = '{3'b001, 32'h0000_2002, 32'h1234_5678, 32'h5678_5678, 4'b1100, 1'b1, 1'b0};
    vecs[3] = '{3'b001, 32'h0000_2000, 32'hCAFE_F00D, 32'hF00D_F00D, 4'b0011, 1'b1, 1'b0};
    vecs[4] = '{3'b000, 32'h0000_4001, 32'h1234_56A5, 32'hA5A5_A5A5, 4'b0010, 1'b1, 1'b0};
    vecs[5] = '{3'b010, 32'h0000_3003, 32'h0102_0304, 32'h0102_0304, 4'b1111, 1'b1, 1'b1};
    vecs[6] = '{3'b011, 32'h0000_6000, 32'h1111_1111, 32'h0,         4'b0000, 1'b0, 1'b0};
    vecs[7] = '{3'b111, 32'h0000_6004, 32'h2222_2222, 32'h0,         4'b0000, 1'b0, 1'b0};
    vecs[8] = '{3'b001, 32'h0000_2003, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, 1'b1, 1'b1};

    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    StSel    = 3'b000;
    mem_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",   {31'd0, mem_req},  32'd0);
    check("rst_mem_addr",  mem_addr,          32'd0);
    check("rst_mem_wdata", mem_wdata,         32'd0);
    check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rst_sb_count",  {29'd0, sb_count}, 32'd0);
    check("rst_sb_empty",  {31'd0, sb_empty}, 32'd1);
    check("rst_st_ready",  {31'd0, st_ready}, 32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
    check("rst_misalign",  {31'd0, st_misalign}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Alignment vectors, ack held high; each push drains before the next
    mem_ack = 1'b1;
    foreach (vecs[k]) begin
`ifdef STORE_MISALIGN_TRAP_EN
      enq = vecs[k].legal && !vecs[k].mis;
`else
      enq = vecs[k].legal;
`endif
      if (enq) expect_store({vecs[k].addr[31:2], 2'b00}, vecs[k].wd, vecs[k].m);
      push_store(vecs[k].sel, vecs[k].addr, vecs[k].data);
      check("vec_count_after_push", {29'd0, sb_count}, {31'd0, enq});
      check("vec_idle_same_cycle",  {31'd0, mem_req},  32'd0);
`ifdef STORE_MISALIGN_TRAP_EN
      check("vec_misalign_pulse", {31'd0, st_misalign}, {31'd0, vecs[k].legal && vecs[k].mis});
`endif
      @(posedge clk); #1;
      check("vec_req_latency", {31'd0, mem_req}, {31'd0, enq});
`ifdef STORE_MISALIGN_TRAP_EN
      check("vec_misalign_drop", {31'd0, st_misalign}, 32'd0);
`endif
      wait_drain();
    end

    // SW held off by mem_ack=0 for 5 cycles; outputs must stay stable
    mem_ack = 1'b0;
    expect_store(32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
    push_store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_req",   {31'd0, mem_req}, 32'd1);
      check("hold_addr",  mem_addr,  32'h0000_3000);
      check("hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("hold_wmask", {28'd0, mem_wmask}, 32'hF);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("hold_popped_count", {29'd0, sb_count}, 32'd0);
    check("hold_popped_req",   {31'd0, mem_req},  32'd0);

    // Fill to DEPTH with ack low; extra request must be ignored
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1;
      StSel    = 3'b010;
      st_addr  = 32'h0000_0100 + 32'(4 * i);
      st_data  = 32'hA000_0000 + 32'(i + 1);
      expect_store(32'h0000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i + 1), 4'b1111);
      @(posedge clk); #1;
    end
    check("full_count", {29'd0, sb_count}, 32'd4);
    check("full_ready", {31'd0, st_ready}, 32'd0);
    st_addr = 32'h0000_0110;
    st_data = 32'hA000_0005;
    repeat (2) @(posedge clk);
    #1;
    st_valid = 1'b0;
    check("full_ignored_count", {29'd0, sb_count}, 32'd4);
    check("full_head_addr", mem_addr, 32'h0000_0100);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("after_pop_count", {29'd0, sb_count}, 32'd3);
    check("after_pop_ready", {31'd0, st_ready}, 32'd1);
    check("after_pop_head",  mem_addr, 32'h0000_0104);
    mem_ack = 1'b1;
    wait_drain();

    // Streaming push with pop every cycle; occupancy settles at 2
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1;
      StSel    = 3'b010;
      st_addr  = 32'h0000_0200 + 32'(4 * i);
      st_data  = 32'h1111_1111 * 32'(i + 1);
      expect_store(32'h0000_0200 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'b1111);
      @(posedge clk); #1;
      if (i >= 1) check("stream_count", {29'd0, sb_count}, 32'd2);
    end
    st_valid = 1'b0;
    wait_drain();

    // Asynchronous reset with pending entries
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_store(3'b000, 32'h0000_0300 + 32'(i), 32'h0000_0055);
    end
    check("pre_rst_count", {29'd0, sb_count}, 32'd3);
    check("pre_rst_req",   {31'd0, mem_req},  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_req",   {31'd0, mem_req},  32'd0);
    check("async_rst_count", {29'd0, sb_count}, 32'd0);
    check("async_rst_empty", {31'd0, sb_empty}, 32'd1);
    check("async_rst_addr",  mem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_req", {31'd0, mem_req}, 32'd0);
    end

    // Normal operation resumes after reset
    mem_ack = 1'b1;
    expect_store(32'h0000_5000, 32'h7C7C_7C7C, 4'b0100);
    push_store(3'b000, 32'h0000_5002, 32'h0000_007C);
    wait_drain();
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
